// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the I/O stage, the UART TX FIFO and the transmitter.
interface uart_tx_fifo_if #(
    parameter int DEPTH_BITWIDTH = 4
);
    logic                      wr_en;
    logic [7:0]                wr_data;
    logic                      full;
    logic                      empty;
    logic [DEPTH_BITWIDTH:0]   count;
    logic                      overflow;
    logic                      clr_overflow;
    logic [7:0]                uarttx_data;
    logic                      uarttx_go;
    logic                      uarttx_bsy;

    modport master (
        output wr_en, wr_data, clr_overflow, uarttx_bsy,
        input  full, empty, count, overflow, uarttx_data, uarttx_go
    );

    modport slave (
        input  wr_en, wr_data, clr_overflow, uarttx_bsy,
        output full, empty, count, overflow, uarttx_data, uarttx_go
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that queues CPU stores to the UART and feeds the
// transmitter one byte at a time over its go/bsy handshake.
module uart_tx_fifo #(
    parameter int DEPTH_BITWIDTH = 4
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_BITWIDTH;
    localparam int CW    = DEPTH_BITWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        SEND,
        GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [7:0]                mem_q [DEPTH];
    logic [DEPTH_BITWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic                      go_q, go_d;
    logic [7:0]                data_q, data_d;
    logic                      full, empty, push, drop, pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wr_en & ~full;
    assign drop  = bus.wr_en & full;
    assign pop   = (state_q == IDLE) & ~empty;

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count_q;
    assign bus.overflow    = ovf_q;
    assign bus.uarttx_data = data_q;
    assign bus.uarttx_go   = go_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // a dropped push beats a simultaneous clear
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        go_d    = go_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    data_d  = mem_q[rd_ptr_q];
                    go_d    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (bus.uarttx_bsy) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!bus.uarttx_bsy) begin
                    go_d    = 1'b0;
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                go_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            go_q     <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            go_q     <= go_d;
            data_q   <= data_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple transmitter model.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    bit   tx_en = 1'b1;
    int   busy_len = 10;
    int   tstate = 0;
    int   tcnt = 0;
    logic [7:0] rx [$];

    uart_tx_fifo_if #(.DEPTH_BITWIDTH(4)) bus ();

    uart_tx_fifo #(.DEPTH_BITWIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // transmitter: bsy rises when go is seen, lasts busy_len cycles
    initial begin
        bus.uarttx_bsy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                tstate = 0;
                bus.uarttx_bsy = 1'b0;
            end else begin
                case (tstate)
                    0: if (tx_en && bus.uarttx_go) begin
                        bus.uarttx_bsy = 1'b1;
                        tcnt = busy_len;
                        rx.push_back(bus.uarttx_data);
                        tstate = 1;
                    end
                    1: begin
                        tcnt--;
                        if (tcnt == 0) begin
                            bus.uarttx_bsy = 1'b0;
                            tstate = 2;
                        end
                    end
                    default: if (!bus.uarttx_go) tstate = 0;
                endcase
            end
        end
    end

    initial begin
        int i;
        int k;
        bit seen;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.clr_overflow = 1'b0;

        // reset and idle
        #1 rst_n = 1'b0;
        #1;
        check("rst_go", bus.uarttx_go, 0);
        check("rst_data", bus.uarttx_data, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_count", bus.count, 0);
        check("rst_ovf", bus.overflow, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("idle_go", bus.uarttx_go, 0);
            check("idle_empty", bus.empty, 1);
            check("idle_count", bus.count, 0);
            check("idle_data", bus.uarttx_data, 0);
        end

        // single byte
        rx.delete();
        busy_len = 10;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        check("sb_count_n1", bus.count, 1);
        check("sb_empty_n1", bus.empty, 0);
        check("sb_go_n1", bus.uarttx_go, 0);
        tick();
        check("sb_go_n2", bus.uarttx_go, 1);
        check("sb_data_n2", bus.uarttx_data, 8'h41);
        check("sb_count_n2", bus.count, 0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (!bus.uarttx_bsy) begin
                seen = 1'b1;
                break;
            end
        end
        check("sb_bsy_fell", seen, 1);
        check("sb_go_at_fall", bus.uarttx_go, 1);
        tick();
        check("sb_go_after", bus.uarttx_go, 0);
        check("sb_rx_n", rx.size(), 1);
        if (rx.size() > 0) check("sb_rx0", rx[0], 8'h41);
        repeat (5) tick();

        // burst with wrap
        rx.delete();
        busy_len = 3;
        i = 0;
        k = 0;
        while (i < 20 && k < 2000) begin
            if (!bus.full) begin
                bus.wr_en = 1'b1;
                bus.wr_data = 8'(i);
                i++;
            end else begin
                bus.wr_en = 1'b0;
            end
            tick();
            k++;
        end
        bus.wr_en = 1'b0;
        k = 0;
        while (rx.size() < 20 && k < 3000) begin
            tick();
            k++;
        end
        check("bw_rx_n", rx.size(), 20);
        for (int j = 0; j < rx.size() && j < 20; j++)
            check($sformatf("bw_rx%0d", j), rx[j], j);
        check("bw_ovf", bus.overflow, 0);
        repeat (10) tick();
        check("bw_count", bus.count, 0);

        // overflow with transmitter stalled in START
        rx.delete();
        tx_en = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA0;
        tick();
        bus.wr_en = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.uarttx_go) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("of_go", seen, 1);
        for (int j = 0; j < 16; j++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'hB0 + 8'(j);
            tick();
        end
        check("of_full", bus.full, 1);
        check("of_count16", bus.count, 16);
        check("of_ovf0", bus.overflow, 0);
        bus.wr_data = 8'hEE;
        tick();
        bus.wr_en = 1'b0;
        check("of_ovf1", bus.overflow, 1);
        check("of_count_keep", bus.count, 16);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("of_clr", bus.overflow, 0);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hEF;
        bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        bus.clr_overflow = 1'b0;
        check("of_set_wins", bus.overflow, 1);
        bus.clr_overflow = 1'b1;
        tick();
        bus.clr_overflow = 1'b0;
        check("of_clr2", bus.overflow, 0);
        tx_en = 1'b1;
        k = 0;
        while (rx.size() < 17 && k < 1000) begin
            tick();
            k++;
        end
        repeat (20) tick();
        check("of_rx_n", rx.size(), 17);
        if (rx.size() >= 17) begin
            check("of_rx_first", rx[0], 8'hA0);
            for (int j = 0; j < 16; j++)
                check($sformatf("of_rx%0d", j + 1), rx[j+1], 8'hB0 + j);
        end

        // simultaneous push and pop
        rx.delete();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h54;
        tick();
        check("pp_count_a", bus.count, 1);
        bus.wr_data = 8'h55;
        tick();
        bus.wr_en = 1'b0;
        check("pp_count_b", bus.count, 1);
        check("pp_go", bus.uarttx_go, 1);
        check("pp_data", bus.uarttx_data, 8'h54);
        k = 0;
        while (rx.size() < 2 && k < 200) begin
            tick();
            k++;
        end
        check("pp_rx_n", rx.size(), 2);
        if (rx.size() >= 2) begin
            check("pp_rx0", rx[0], 8'h54);
            check("pp_rx1", rx[1], 8'h55);
        end
        repeat (10) tick();

        // reset in the middle of SEND
        rx.delete();
        busy_len = 30;
        for (int j = 0; j < 6; j++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'hC0 + 8'(j);
            tick();
        end
        bus.wr_en = 1'b0;
        check("mr_count5", bus.count, 5);
        check("mr_go1", bus.uarttx_go, 1);
        check("mr_bsy", bus.uarttx_bsy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mr_go_async", bus.uarttx_go, 0);
        check("mr_count_async", bus.count, 0);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.uarttx_go !== 1'b0) seen = 1'b1;
        end
        check("mr_no_go", seen, 0);
        check("mr_count0", bus.count, 0);
        check("mr_empty", bus.empty, 1);
        check("mr_rx_n", rx.size(), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
